// File: rtl/button_conditioner.sv
// Debounces two raw push-buttons: stop toggles a run/pause level, back emits
// single-cycle pulses with auto-repeat while held.
module button_conditioner #(
    parameter int unsigned DEBOUNCE       = 1000000,
    parameter int unsigned REPEAT         = 25000000,
    parameter int unsigned CNT_W          = 25,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic iclk,
    input  logic irst,
    input  logic ibtn_stop,
    input  logic ibtn_back,
    output logic ostop,
    output logic oback,
    output logic ostop_evt
);

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        BOUNCE_PRESS   = 2'd1,
        PRESSED        = 2'd2,
        BOUNCE_RELEASE = 2'd3
    } state_t;

    localparam logic             IDLE_LVL = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;
    // The transition fires on the cycle the counter would reach DEBOUNCE-1.
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE - 2);
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT - 1);

    // Channel 0 = stop, channel 1 = back.
    logic [1:0] raw_pin;
    logic [1:0] press_evt;
    logic [1:0] in_pressed;
    logic [1:0] level_pressed;

    assign raw_pin = {ibtn_back, ibtn_stop};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic             meta_q;
            logic             sync_q;
            logic             pressed;
            logic             evt;
            state_t           state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            assign pressed = BTN_ACTIVE_LOW ? ~sync_q : sync_q;

            always_ff @(posedge iclk or negedge irst) begin
                if (!irst) begin
                    meta_q  <= IDLE_LVL;
                    sync_q  <= IDLE_LVL;
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    meta_q  <= raw_pin[gi];
                    sync_q  <= meta_q;
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                evt     = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (pressed) begin
                            state_d = BOUNCE_PRESS;
                            cnt_d   = '0;
                        end
                    end
                    BOUNCE_PRESS: begin
                        if (!pressed) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_d = PRESSED;
                            cnt_d   = '0;
                            evt     = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (!pressed) begin
                            state_d = BOUNCE_RELEASE;
                            cnt_d   = '0;
                        end
                    end
                    BOUNCE_RELEASE: begin
                        if (pressed) begin
                            state_d = PRESSED;
                            cnt_d   = '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            assign press_evt[gi]     = evt;
            assign in_pressed[gi]    = (state_q == PRESSED);
            assign level_pressed[gi] = pressed;
        end
    endgenerate

    logic             ostop_q, ostop_d;
    logic             ostop_evt_q, ostop_evt_d;
    logic             oback_q, oback_d;
    logic [CNT_W-1:0] rep_q, rep_d;

    always_comb begin
        ostop_d     = ostop_q ^ press_evt[0];
        ostop_evt_d = press_evt[0];
        oback_d     = press_evt[1];
        rep_d       = '0;
        // Repeat counter only advances while the back channel stays in PRESSED.
        if (in_pressed[1]) begin
            if (rep_q == REP_LAST) begin
                oback_d = 1'b1;
            end else if (level_pressed[1]) begin
                rep_d = rep_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            ostop_q     <= 1'b1;
            ostop_evt_q <= 1'b0;
            oback_q     <= 1'b0;
            rep_q       <= '0;
        end else begin
            ostop_q     <= ostop_d;
            ostop_evt_q <= ostop_evt_d;
            oback_q     <= oback_d;
            rep_q       <= rep_d;
        end
    end

    assign ostop     = ostop_q;
    assign ostop_evt = ostop_evt_q;
    assign oback     = oback_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed table-driven bench for button_conditioner with DEBOUNCE=4, REPEAT=8;
// a few hand-written sequences cover asynchronous reset during a hold.
module tb_button_conditioner;

    logic iclk;
    logic irst;
    logic btn_stop;
    logic btn_back;
    logic ostop;
    logic oback;
    logic ostop_evt;

    int total;
    int passed;

    button_conditioner #(
        .DEBOUNCE      (4),
        .REPEAT        (8),
        .CNT_W         (4),
        .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .iclk     (iclk),
        .irst     (irst),
        .ibtn_stop(btn_stop),
        .ibtn_back(btn_back),
        .ostop    (ostop),
        .oback    (oback),
        .ostop_evt(ostop_evt)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    typedef struct {
        logic stop_pin;
        logic back_pin;
        logic e_stop;
        logic e_back;
        logic e_evt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input string sig, input int cyc,
                       input logic act, input logic exp);
        total++;
        if (act !== exp)
            $display("FAIL %s %s cycle %0d: got %b expected %b", name, sig, cyc, act, exp);
        else
            passed++;
    endtask

    task automatic add(input logic sp, input logic bp, input logic es,
                       input logic eb, input logic ee);
        vec_t v;
        v.stop_pin = sp;
        v.back_pin = bp;
        v.e_stop   = es;
        v.e_back   = eb;
        v.e_evt    = ee;
        tbl.push_back(v);
    endtask

    // Cycle c: outputs sampled 1 ns after edge c, then pins for cycle c applied.
    task automatic run_table(input string name);
        int fails_before;
        fails_before = total - passed;
        for (int c = 0; c < tbl.size(); c++) begin
            @(posedge iclk);
            #1;
            chk(name, "ostop", c, ostop, tbl[c].e_stop);
            chk(name, "oback", c, oback, tbl[c].e_back);
            chk(name, "ostop_evt", c, ostop_evt, tbl[c].e_evt);
            btn_stop = tbl[c].stop_pin;
            btn_back = tbl[c].back_pin;
        end
        $display("%s: %0d cycles, %0d mismatching checks", name, tbl.size(),
                 (total - passed) - fails_before);
        tbl.delete();
    endtask

    task automatic do_reset(input string name, input bit idle_pins);
        @(posedge iclk);
        #1;
        irst = 1'b0;
        if (idle_pins) begin
            btn_stop = 1'b1;
            btn_back = 1'b1;
        end
        #1;
        chk(name, "rst_ostop", 0, ostop, 1'b1);
        chk(name, "rst_oback", 0, oback, 1'b0);
        chk(name, "rst_evt", 0, ostop_evt, 1'b0);
        repeat (3) @(posedge iclk);
        #1;
        irst = 1'b1;
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        irst     = 1'b0;
        btn_stop = 1'b1;
        btn_back = 1'b1;

        // Reset and 20 idle cycles
        do_reset("reset", 1'b1);
        for (int c = 0; c < 20; c++) add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run_table("reset_idle");

        // Clean stop press, release 10 cycles, press again
        for (int c = 0; c < 56; c++) begin
            logic sp;
            sp = (c < 20) ? 1'b0 : (c < 30) ? 1'b1 : (c < 46) ? 1'b0 : 1'b1;
            add(sp, 1'b1, (c < 6) ? 1'b1 : (c < 36) ? 1'b0 : 1'b1, 1'b0,
                (c == 6 || c == 36) ? 1'b1 : 1'b0);
        end
        run_table("clean_stop");

        // Bouncy stop press, then a 3-cycle glitch
        do_reset("bouncy_rst", 1'b1);
        for (int c = 0; c < 46; c++) begin
            logic sp;
            if (c < 4)       sp = (c % 2 == 0) ? 1'b0 : 1'b1;
            else if (c < 20) sp = 1'b0;
            else if (c < 30) sp = 1'b1;
            else if (c < 33) sp = 1'b0;
            else             sp = 1'b1;
            add(sp, 1'b1, (c < 10) ? 1'b1 : 1'b0, 1'b0, (c == 10) ? 1'b1 : 1'b0);
        end
        run_table("bouncy_stop");

        // Back held 40 cycles with auto-repeat
        do_reset("back_rst", 1'b1);
        for (int c = 0; c < 56; c++) begin
            logic eb;
            eb = (c >= 6 && c <= 38 && ((c - 6) % 8) == 0) ? 1'b1 : 1'b0;
            add(1'b1, (c < 40) ? 1'b0 : 1'b1, 1'b1, eb, 1'b0);
        end
        run_table("back_hold");

        // Simultaneous presses
        do_reset("both_rst", 1'b1);
        for (int c = 0; c < 25; c++) begin
            logic p;
            p = (c < 10) ? 1'b0 : 1'b1;
            add(p, p, (c < 6) ? 1'b1 : 1'b0, (c == 6) ? 1'b1 : 1'b0,
                (c == 6) ? 1'b1 : 1'b0);
        end
        run_table("both");

        // Reset mid-hold: back held through reset, full debounce again afterwards
        do_reset("hold_rst", 1'b1);
        for (int c = 0; c < 10; c++)
            add(1'b1, 1'b0, 1'b1, (c == 6) ? 1'b1 : 1'b0, 1'b0);
        run_table("hold_pre");
        @(posedge iclk);
        #1;
        irst = 1'b0;
        #1;
        chk("hold_mid", "oback", 10, oback, 1'b0);
        chk("hold_mid", "ostop", 10, ostop, 1'b1);
        chk("hold_mid", "ostop_evt", 10, ostop_evt, 1'b0);
        for (int k = 11; k <= 12; k++) begin
            @(posedge iclk);
            #1;
            chk("hold_mid", "oback", k, oback, 1'b0);
        end
        irst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge iclk);
            #1;
            chk("hold_post", "oback", k, oback, (k == 6) ? 1'b1 : 1'b0);
            chk("hold_post", "ostop_evt", k, ostop_evt, 1'b0);
        end
        $display("hold_post: 12 cycles after reset release checked");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
